// File: rtl/sbox_scheduler_if.sv
// sbox_scheduler_if: groups every non-clock signal of sbox_scheduler.
//   st_req_*  : 128-bit SubBytes job request (valid/ready), byte i = [8i+7:8i]
//   kw_req_*  : 32-bit SubWord job request (valid/ready)
//   st_rsp_*  : substituted state response (valid/ready)
//   kw_rsp_*  : substituted word response (valid/ready)
//   sbox_in/sbox_out : byte lookup to/from the external combinational S-box
//   busy      : scheduler is not idle
// modport slave is taken by the scheduler, modport master by the requester side.
interface sbox_scheduler_if;
  logic         st_req_valid;
  logic [127:0] st_req_data;
  logic         st_req_ready;
  logic         kw_req_valid;
  logic [31:0]  kw_req_data;
  logic         kw_req_ready;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;
  logic         st_rsp_valid;
  logic [127:0] st_rsp_data;
  logic         st_rsp_ready;
  logic         kw_rsp_valid;
  logic [31:0]  kw_rsp_data;
  logic         kw_rsp_ready;
  logic         busy;

  modport slave (
    input  st_req_valid, st_req_data, kw_req_valid, kw_req_data,
    input  sbox_out, st_rsp_ready, kw_rsp_ready,
    output st_req_ready, kw_req_ready, sbox_in,
    output st_rsp_valid, st_rsp_data, kw_rsp_valid, kw_rsp_data, busy
  );

  modport master (
    output st_req_valid, st_req_data, kw_req_valid, kw_req_data,
    output sbox_out, st_rsp_ready, kw_rsp_ready,
    input  st_req_ready, kw_req_ready, sbox_in,
    input  st_rsp_valid, st_rsp_data, kw_rsp_valid, kw_rsp_data, busy
  );
endinterface

// File: rtl/sbox_scheduler.sv
// sbox_scheduler: shares one byte-wide S-box between the SubBytes (16-byte state)
// and SubWord (4-byte key word) requesters. One job at a time, one byte per cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sbox_scheduler_if.slave (request, response, S-box and busy signals)
module sbox_scheduler (
  input  logic             clk,
  input  logic             rst_n,
  sbox_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StRunSt, StRunKw, StRspSt, StRspKw} state_e;
  typedef enum logic {GrantSt, GrantKw} grant_e;

  state_e       state_q, state_d;
  logic [127:0] buf_q, buf_d;
  logic [3:0]   cnt_q, cnt_d;
  grant_e       last_q, last_d;

  logic         idle;
  logic         st_ready, kw_ready;
  logic [7:0]   cur_byte;

  assign idle     = (state_q == StIdle);
  // Round-robin tie-break: a requester waits only if the other is valid and
  // was not the one served last.
  assign st_ready = idle && (!bus.kw_req_valid || (last_q == GrantKw));
  assign kw_ready = idle && (!bus.st_req_valid || (last_q == GrantSt));
  assign cur_byte = buf_q[{cnt_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (bus.st_req_valid && st_ready) begin
          buf_d   = bus.st_req_data;
          cnt_d   = 4'd0;
          last_d  = GrantSt;
          state_d = StRunSt;
        end else if (bus.kw_req_valid && kw_ready) begin
          buf_d   = {96'd0, bus.kw_req_data};
          cnt_d   = 4'd0;
          last_d  = GrantKw;
          state_d = StRunKw;
        end
      end
      StRunSt: begin
        buf_d[{cnt_q, 3'b000} +: 8] = bus.sbox_out;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = StRspSt;
      end
      StRunKw: begin
        buf_d[{cnt_q, 3'b000} +: 8] = bus.sbox_out;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd3) state_d = StRspKw;
      end
      StRspSt: begin
        if (bus.st_rsp_ready) state_d = StIdle;
      end
      StRspKw: begin
        if (bus.kw_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
      cnt_q   <= 4'd0;
      last_q  <= GrantSt;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // All outputs decode directly from registered state, so none glitch on inputs
  // except the readies, which by design follow the other requester's valid.
  assign bus.st_req_ready = st_ready;
  assign bus.kw_req_ready = kw_ready;
  assign bus.sbox_in      = (state_q == StRunSt || state_q == StRunKw) ? cur_byte : 8'h00;
  assign bus.st_rsp_valid = (state_q == StRspSt);
  assign bus.kw_rsp_valid = (state_q == StRspKw);
  assign bus.st_rsp_data  = buf_q;
  assign bus.kw_rsp_data  = buf_q[31:0];
  assign bus.busy         = !idle;

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb_sbox_scheduler: directed plus randomized bench for sbox_scheduler, checked
// every cycle against a job-level reference model and a few literal expectations.
module tb_sbox_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sbox_scheduler_if bus ();

  sbox_scheduler u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // AES S-box, entry 0 in the most significant byte.
  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_flat[(255 - int'(x)) * 8 +: 8];
  endfunction

  // Substitute the low n bytes, leave the rest untouched.
  function automatic logic [127:0] sub_n(input logic [127:0] x, input int n);
    logic [127:0] r;
    r = x;
    for (int j = 0; j < n; j++) r[8*j +: 8] = sb(x[8*j +: 8]);
    return r;
  endfunction

  assign bus.sbox_out = sb(bus.sbox_in);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level reference model: phase 0 idle, 1 looking up, 2 response pending.
  int           m_phase = 0;
  bit           m_kw = 1'b0;
  int           m_k = 0;
  logic [127:0] m_in = '0;
  logic [127:0] m_out = '0;
  bit           m_last_kw = 1'b0;
  logic         m_st_rdy, m_kw_rdy;

  assign m_st_rdy = (m_phase == 0) && (!bus.kw_req_valid || m_last_kw);
  assign m_kw_rdy = (m_phase == 0) && (!bus.st_req_valid || !m_last_kw);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_kw <= 1'b0; m_k <= 0; m_in <= '0; m_out <= '0; m_last_kw <= 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.st_req_valid && m_st_rdy) begin
            m_phase <= 1; m_kw <= 1'b0; m_k <= 0; m_last_kw <= 1'b0;
            m_in <= bus.st_req_data; m_out <= sub_n(bus.st_req_data, 16);
          end else if (bus.kw_req_valid && m_kw_rdy) begin
            m_phase <= 1; m_kw <= 1'b1; m_k <= 0; m_last_kw <= 1'b1;
            m_in <= {96'd0, bus.kw_req_data}; m_out <= sub_n({96'd0, bus.kw_req_data}, 4);
          end
        end
        1: begin
          if (m_k == (m_kw ? 3 : 15)) m_phase <= 2;
          else m_k <= m_k + 1;
        end
        default: begin
          if (m_kw ? bus.kw_rsp_ready : bus.st_rsp_ready) m_phase <= 0;
        end
      endcase
    end
  end

  task automatic compare_all();
    logic [127:0] view;
    logic [7:0]   exp_sb;
    view   = m_out;
    exp_sb = 8'h00;
    if (m_phase == 1) begin
      exp_sb = m_in[8*m_k +: 8];
      for (int j = 0; j < 16; j++) view[8*j +: 8] = (j < m_k) ? m_out[8*j +: 8] : m_in[8*j +: 8];
    end
    chk("st_req_ready", 128'(bus.st_req_ready), 128'(m_st_rdy));
    chk("kw_req_ready", 128'(bus.kw_req_ready), 128'(m_kw_rdy));
    chk("busy", 128'(bus.busy), 128'(m_phase != 0));
    chk("sbox_in", 128'(bus.sbox_in), 128'(exp_sb));
    chk("st_rsp_valid", 128'(bus.st_rsp_valid), 128'(m_phase == 2 && !m_kw));
    chk("kw_rsp_valid", 128'(bus.kw_rsp_valid), 128'(m_phase == 2 && m_kw));
    chk("st_rsp_data", bus.st_rsp_data, view);
    chk("kw_rsp_data", 128'(bus.kw_rsp_data), 128'(view[31:0]));
  endtask

  always @(negedge clk) compare_all();

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input bit kw, output int n);
    n = 0;
    while (!(kw ? bus.kw_rsp_valid : bus.st_rsp_valid) && n < 60) begin
      cyc();
      n++;
    end
    if (n >= 60) chk("rsp_timeout", 128'(n), 128'(0));
  endtask

  initial begin
    int           n;
    logic [127:0] hold;
    logic [127:0] d;
    logic [7:0]   kw_seq [4];
    kw_seq = '{8'h09, 8'h3c, 8'h4f, 8'hcf};

    bus.st_req_valid = 1'b0; bus.st_req_data = '0;
    bus.kw_req_valid = 1'b0; bus.kw_req_data = '0;
    bus.st_rsp_ready = 1'b1; bus.kw_rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    cyc(); cyc();
    chk("reset_busy", 128'(bus.busy), 128'(0));
    chk("reset_st_rsp_data", bus.st_rsp_data, 128'd0);
    chk("reset_readies", 128'({bus.st_req_ready, bus.kw_req_ready}), 128'(2'b11));
    rst_n = 1'b1;
    cyc();

    // All-zero state: 16 lookups of 0x00 give 0x63 everywhere.
    bus.st_req_data = '0; bus.st_req_valid = 1'b1;
    #1 chk("st_first_ready", 128'(bus.st_req_ready), 128'(1));
    cyc();
    bus.st_req_valid = 1'b0;
    n = 0;
    while (!bus.st_rsp_valid && n < 60) begin
      if (n < 16) chk("st_zero_sbox_in", 128'(bus.sbox_in), 128'(0));
      cyc();
      n++;
    end
    chk("st_latency", 128'(n), 128'(16));
    chk("st_zero_result", bus.st_rsp_data, {16{8'h63}});
    cyc();

    // Key word cf4f3c09 -> 8a84eb01, lookups in byte order 0..3.
    bus.kw_req_data = 32'hcf4f3c09; bus.kw_req_valid = 1'b1;
    cyc();
    bus.kw_req_valid = 1'b0;
    n = 0;
    while (!bus.kw_rsp_valid && n < 60) begin
      if (n < 4) chk("kw_sbox_seq", 128'(bus.sbox_in), 128'(kw_seq[n]));
      cyc();
      n++;
    end
    chk("kw_latency", 128'(n), 128'(4));
    chk("kw_result", 128'(bus.kw_rsp_data), 128'(32'h8a84eb01));
    cyc();

    // Tie straight after reset: KW first, ST in the first idle after the KW response.
    rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
    bus.st_req_data = {$urandom, $urandom, $urandom, $urandom};
    bus.kw_req_data = $urandom;
    bus.st_req_valid = 1'b1; bus.kw_req_valid = 1'b1;
    #1 chk("tie_kw_wins", 128'({bus.st_req_ready, bus.kw_req_ready}), 128'(2'b01));
    cyc();
    bus.kw_req_valid = 1'b0;
    wait_rsp(1'b1, n);
    cyc();
    chk("tie_idle_st_ready", 128'({bus.busy, bus.st_req_ready}), 128'(2'b01));
    cyc();
    chk("tie_st_taken", 128'({bus.busy, bus.st_req_ready}), 128'(2'b10));
    bus.st_req_valid = 1'b0;
    wait_rsp(1'b0, n);
    cyc();
    bus.st_req_valid = 1'b1; bus.kw_req_valid = 1'b1;
    cyc();
    bus.st_req_valid = 1'b0; bus.kw_req_valid = 1'b0;
    repeat (20) cyc();

    // Stalled ST response blocks a waiting KW request until the handshake.
    bus.st_rsp_ready = 1'b0;
    bus.st_req_data = {$urandom, $urandom, $urandom, $urandom};
    bus.st_req_valid = 1'b1;
    cyc();
    bus.st_req_valid = 1'b0;
    bus.kw_req_data = $urandom; bus.kw_req_valid = 1'b1;
    wait_rsp(1'b0, n);
    hold = bus.st_rsp_data;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 128'(bus.st_rsp_valid), 128'(1));
      chk("stall_data", bus.st_rsp_data, hold);
      chk("stall_kw_blocked", 128'(bus.kw_req_ready), 128'(0));
      cyc();
    end
    bus.st_rsp_ready = 1'b1;
    cyc();
    chk("stall_after_hs", 128'({bus.busy, bus.kw_req_ready}), 128'(2'b01));
    cyc();
    chk("stall_kw_taken", 128'({bus.busy, bus.kw_req_ready}), 128'(2'b10));
    bus.kw_req_valid = 1'b0;
    wait_rsp(1'b1, n);
    cyc();

    // Reset in the middle of an ST job, then rerun it.
    d = {$urandom, $urandom, $urandom, $urandom};
    d[15:0] = 16'h0153;
    bus.st_req_data = d; bus.st_req_valid = 1'b1;
    cyc();
    bus.st_req_valid = 1'b0;
    repeat (7) cyc();
    chk("mid_byte7", 128'(bus.sbox_in), 128'(d[63:56]));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(bus.busy), 128'(0));
    chk("mid_rst_sbox_in", 128'(bus.sbox_in), 128'(0));
    chk("mid_rst_valids", 128'({bus.st_rsp_valid, bus.kw_rsp_valid}), 128'(0));
    chk("mid_rst_data", bus.st_rsp_data, 128'd0);
    chk("mid_rst_readies", 128'({bus.st_req_ready, bus.kw_req_ready}), 128'(2'b11));
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    bus.st_req_valid = 1'b1;
    cyc();
    bus.st_req_valid = 1'b0;
    wait_rsp(1'b0, n);
    chk("rerun_byte0", 128'(bus.st_rsp_data[7:0]), 128'(8'hed));
    chk("rerun_byte1", 128'(bus.st_rsp_data[15:8]), 128'(8'h7c));
    chk("rerun_full", bus.st_rsp_data, sub_n(d, 16));
    cyc();

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      bus.st_req_valid = ($urandom_range(0, 9) < 4);
      bus.kw_req_valid = ($urandom_range(0, 9) < 4);
      bus.st_req_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.kw_req_data  = $urandom;
      bus.st_rsp_ready = ($urandom_range(0, 9) < 6);
      bus.kw_rsp_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    bus.st_req_valid = 1'b0; bus.kw_req_valid = 1'b0;
    bus.st_rsp_ready = 1'b1; bus.kw_rsp_ready = 1'b1;
    repeat (40) cyc();
    chk("final_idle", 128'(bus.busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
